weight_memory_bank_para: RTL and testbench
==========================================

WEIGHT_MEMORY_BANK_PARA -- requirements
Module: weight_memory_bank_para

Interface
REQ-001 SHALL have parameter DATA_W, default 30, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7, meaning word address width; depth is fixed at 2^ADDR_W.
REQ-003 SHALL have parameter BANKS, default 8, meaning parallel banks read in lockstep.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port WR  in  1  write strobe.
REQ-007 SHALL have port wr_bank  in  max(1,clog2(BANKS))  target bank for the write.
REQ-008 SHALL have port wr_address_word  in  ADDR_W  write word address.
REQ-009 SHALL have port wr_data_word  in  DATA_W  write data.
REQ-010 SHALL have port burst_start  in  1  single-cycle request to start a read burst.
REQ-011 SHALL have port burst_base  in  ADDR_W  first read address.
REQ-012 SHALL have port burst_len  in  ADDR_W+1  number of words, 1..2^ADDR_W.
REQ-013 SHALL have port hold  in  1  stall; freezes burst progress and outputs.
REQ-014 SHALL have port busy  out  1  burst in progress.
REQ-015 SHALL have port rd_valid  out  1  data_words valid this cycle.
REQ-016 SHALL have port rd_address_word  out  ADDR_W  address that produced data_words.
REQ-017 SHALL have port data_words  out  BANKS*DATA_W  bank b at bits [b*DATA_W +: DATA_W].
REQ-018 SHALL have port burst_done  out  1  high together with the final rd_valid of a burst.

Function
REQ-019 SHALL write wr_data_word into bank wr_bank at wr_address_word on the edge where WR=1; WR with wr_bank>=BANKS is ignored.
REQ-020 SHALL read all banks synchronously at one shared address, 1-cycle latency (M9K-inferable); no combinational read path.
REQ-021 SHALL implement FSM IDLE/RUN: IDLE->RUN on burst_start=1 with burst_len!=0, capturing base and length; burst_len=0 is ignored.
REQ-022 SHALL issue one address per non-hold cycle in RUN, starting at burst_base and incrementing modulo 2^ADDR_W (wrap 127->0 at default).
REQ-023 SHALL leave RUN for IDLE in the cycle after the last address is issued.
REQ-024 SHALL assert rd_valid exactly one non-hold cycle after each address issue, with rd_address_word equal to that address; first rd_valid appears 2 cycles after burst_start.
REQ-025 SHALL assert burst_done only with the last rd_valid of a burst, for one non-hold cycle.
REQ-026 SHALL keep busy high from the cycle after an accepted burst_start through the cycle carrying burst_done, inclusive.
REQ-027 SHALL ignore burst_start while busy=1.
REQ-028 SHALL, while hold=1, freeze the issue counter, read pipeline, rd_valid, rd_address_word, data_words and burst_done; writes still proceed.
REQ-029 SHALL, for a read and write to the same bank/address in the same cycle, return the old data.
REQ-030 SHALL deliver back-to-back bursts: burst_start accepted in the cycle after burst_done; no gap beyond the 2-cycle start latency.

Reset
REQ-031 SHALL, on RESET=1 at a clock edge, set FSM to IDLE, clear busy, rd_valid, burst_done, rd_address_word, data_words to 0.
REQ-032 SHALL abort a burst on reset mid-operation, with no further rd_valid or burst_done from it.
REQ-033 SHALL not clear memory contents on reset; WR with RESET=1 is ignored.

Structure
REQ-034 SHALL place default DATA_W, ADDR_W, BANKS and FSM state encodings in shared package nn_mem_pkg.
REQ-035 SHALL instantiate BANKS copies of sub-module memory_bank_sdp (one write port, one synchronous read port, DATA_W x 2^ADDR_W).

Verification
REQ-036 SHALL cover: write bank3 addr5=0x1234567; burst base5 len1 -> 2 cycles later rd_valid=1, burst_done=1, bank3 slice=0x1234567, rd_address_word=5.
REQ-037 SHALL cover: banks preloaded with addr*8+bank; burst base126 len4 -> addresses 126,127,0,1 on consecutive cycles, busy high 5 cycles.
REQ-038 SHALL cover: hold=1 for 3 cycles mid-burst of len8 -> outputs frozen, 8 valids total, order intact, burst_done on 8th.
REQ-039 SHALL cover: WR to addr10 same cycle as its read issue -> old value returned; rereading addr10 returns new value.
REQ-040 SHALL cover: RESET asserted 3 cycles into len16 burst -> all outputs 0 next cycle, no burst_done; memory contents preserved on reread.
REQ-041 SHALL cover: burst_len=0 and burst_start while busy -> ignored, no extra rd_valid; burst_len=128 -> 128 valids, all addresses.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// Shared defaults and sequencer state encodings for the parallel weight memory.
package nn_mem_pkg;

    localparam int DEF_DATA_W = 30;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_BANKS  = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // A single bank still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_bank_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, read-old-data on collision.
module memory_bank_sdp #(
    parameter int DATA_W = 30,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Output register only; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (clr)     q <= '0;
        else if (re) q <= mem[rd_addr];
    end

endmodule

// File: rtl/weight_memory_bank_para.sv
// BANKS weight RAMs read in lockstep by a burst sequencer with stall support.
//   state   | meaning
//   ST_IDLE | waiting for burst_start with nonzero length
//   ST_RUN  | issuing one read address per non-hold cycle
module weight_memory_bank_para
    import nn_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANKS  = DEF_BANKS
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         WR,
    input  logic [sel_width(BANKS)-1:0]  wr_bank,
    input  logic [ADDR_W-1:0]            wr_address_word,
    input  logic [DATA_W-1:0]            wr_data_word,
    input  logic                         burst_start,
    input  logic [ADDR_W-1:0]            burst_base,
    input  logic [ADDR_W:0]              burst_len,
    input  logic                         hold,
    output logic                         busy,
    output logic                         rd_valid,
    output logic [ADDR_W-1:0]            rd_address_word,
    output logic [BANKS*DATA_W-1:0]      data_words,
    output logic                         burst_done
);

    localparam int BANK_W = sel_width(BANKS);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   left;
    logic              issue;
    logic              last_issue;
    logic              start_ok;

    assign issue      = (state == ST_RUN) && !hold;
    assign last_issue = issue && (left == (ADDR_W+1)'(1));
    // busy spans the trailing burst_done cycle after the FSM has already returned to idle.
    assign busy       = (state == ST_RUN) || burst_done;
    assign start_ok   = burst_start && !busy && (burst_len != '0);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state           <= ST_IDLE;
            cur_addr        <= '0;
            left            <= '0;
            rd_valid        <= 1'b0;
            rd_address_word <= '0;
            burst_done      <= 1'b0;
        end else begin
            if (!hold) begin
                rd_valid   <= issue;
                burst_done <= last_issue;
                if (issue) rd_address_word <= cur_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state    <= ST_RUN;
                        cur_addr <= burst_base;
                        left     <= burst_len;
                    end
                end
                default: begin
                    if (issue) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        left     <= left - (ADDR_W+1)'(1);
                        if (last_issue) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic we_b;
        assign we_b = WR && !RESET && (wr_bank == BANK_W'(b));

        memory_bank_sdp #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (CLOCK_50),
            .clr     (RESET),
            .we      (we_b),
            .wr_addr (wr_address_word),
            .wr_data (wr_data_word),
            .re      (issue),
            .rd_addr (cur_addr),
            .q       (data_words[b*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_weight_memory_bank_para.sv
// Scoreboard bench for the parallel weight memory: expected reads queued at burst start.
module tb_weight_memory_bank_para;

    localparam int DW    = 30;
    localparam int AW    = 7;
    localparam int NB    = 8;
    localparam int BW    = 3;
    localparam int DEPTH = 128;

    logic              CLOCK_50 = 1'b0;
    logic              RESET = 1'b1;
    logic              WR = 1'b0;
    logic [BW-1:0]     wr_bank = '0;
    logic [AW-1:0]     wr_address_word = '0;
    logic [DW-1:0]     wr_data_word = '0;
    logic              burst_start = 1'b0;
    logic [AW-1:0]     burst_base = '0;
    logic [AW:0]       burst_len = '0;
    logic              hold = 1'b0;
    logic              busy;
    logic              rd_valid;
    logic [AW-1:0]     rd_address_word;
    logic [NB*DW-1:0]  data_words;
    logic              burst_done;

    weight_memory_bank_para #(.DATA_W(DW), .ADDR_W(AW), .BANKS(NB)) dut (
        .CLOCK_50        (CLOCK_50),
        .RESET           (RESET),
        .WR              (WR),
        .wr_bank         (wr_bank),
        .wr_address_word (wr_address_word),
        .wr_data_word    (wr_data_word),
        .burst_start     (burst_start),
        .burst_base      (burst_base),
        .burst_len       (burst_len),
        .hold            (hold),
        .busy            (busy),
        .rd_valid        (rd_valid),
        .rd_address_word (rd_address_word),
        .data_words      (data_words),
        .burst_done      (burst_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [NB*DW-1:0] data;
        logic             last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [NB][DEPTH];
    int n_chk = 0, n_err = 0, n_valid = 0, n_done = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NB*DW-1:0] pack(input int a);
        logic [NB*DW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = model[b][a];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_write(input int b, input int a, input logic [DW-1:0] d);
        WR = 1'b1;
        wr_bank = BW'(b);
        wr_address_word = AW'(a);
        wr_data_word = d;
        tick();
        WR = 1'b0;
        if (b < NB && !RESET) model[b][a] = d;
    endtask

    task automatic start_burst(input int base, input int len, input bit accept);
        if (accept) begin
            for (int i = 0; i < len; i++) begin
                exp_t e;
                int a;
                a = (base + i) % DEPTH;
                e.addr = AW'(a);
                e.data = pack(a);
                e.last = (i == len - 1);
                exp_q.push_back(e);
            end
        end
        burst_start = 1'b1;
        burst_base = AW'(base);
        burst_len = (AW+1)'(len);
        tick();
        burst_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check_val("idle_timeout", 256'(busy || exp_q.size() != 0), 256'(0));
    endtask

    // A frozen output is consumed once, on the cycle hold is released.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (!RESET && rd_valid && !hold) begin
            n_valid++;
            if (burst_done) n_done++;
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", 256'(rd_valid), 256'(0));
            end else begin
                e = exp_q.pop_front();
                check_val("rd_addr", 256'(rd_address_word), 256'(e.addr));
                check_val("rd_data", 256'(data_words), 256'(e.data));
                check_val("rd_done", 256'(burst_done), 256'(e.last));
            end
        end
        if (!RESET && burst_done && !rd_valid)
            check_val("done_without_valid", 256'(burst_done), 256'(0));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nd, nbusy, nvb;
        logic [NB*DW-1:0] snap_d;
        logic [AW-1:0]    snap_a;
        logic             snap_v;

        repeat (2) tick();
        check_val("rst_busy", 256'(busy), 256'(0));
        check_val("rst_valid", 256'(rd_valid), 256'(0));
        check_val("rst_done", 256'(burst_done), 256'(0));
        check_val("rst_addr", 256'(rd_address_word), 256'(0));
        check_val("rst_data", 256'(data_words), 256'(0));
        RESET = 1'b0;

        for (int a = 0; a < DEPTH; a++)
            for (int b = 0; b < NB; b++)
                do_write(b, a, DW'(a * 8 + b));

        // single-word burst, two-cycle latency
        do_write(3, 5, 30'h1234567);
        start_burst(5, 1, 1);
        check_val("lat_c1_valid", 256'(rd_valid), 256'(0));
        check_val("lat_c1_busy", 256'(busy), 256'(1));
        tick();
        check_val("lat_c2_valid", 256'(rd_valid), 256'(1));
        check_val("lat_c2_done", 256'(burst_done), 256'(1));
        check_val("lat_c2_bank3", 256'(data_words[3*DW +: DW]), 256'(30'h1234567));
        check_val("lat_c2_addr", 256'(rd_address_word), 256'(5));
        wait_idle(10);

        // wraparound burst; busy spans five cycles
        start_burst(126, 4, 1);
        nbusy = 0;
        nvb = 0;
        while (busy && nbusy < 20) begin
            nbusy++;
            if (rd_valid) nvb++;
            tick();
        end
        check_val("wrap_busy_cycles", 256'(nbusy), 256'(5));
        check_val("wrap_valid_cycles", 256'(nvb), 256'(4));
        wait_idle(10);

        // hold for three cycles mid-burst
        start_burst(20, 8, 1);
        nv = n_valid;
        nd = n_done;
        tick();
        tick();
        hold = 1'b1;
        snap_d = data_words;
        snap_a = rd_address_word;
        snap_v = rd_valid;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_data", 256'(data_words), 256'(snap_d));
            check_val("hold_addr", 256'(rd_address_word), 256'(snap_a));
            check_val("hold_valid", 256'(rd_valid), 256'(snap_v));
        end
        hold = 1'b0;
        wait_idle(30);
        check_val("hold_nvalid", 256'(n_valid - nv), 256'(8));
        check_val("hold_ndone", 256'(n_done - nd), 256'(1));

        // write collides with read issue: old data, then new on reread
        start_burst(10, 1, 1);
        do_write(2, 10, 30'h2ABCDEF);
        wait_idle(10);
        start_burst(10, 1, 1);
        wait_idle(10);

        // back-to-back: start accepted in the cycle after burst_done
        start_burst(60, 2, 1);
        for (int i = 0; i < 10 && !burst_done; i++) tick();
        check_val("b2b_done_seen", 256'(burst_done), 256'(1));
        tick();
        start_burst(62, 2, 1);
        check_val("b2b_accept", 256'(busy), 256'(1));
        wait_idle(10);

        // reset mid-burst, with an ignored write during reset
        start_burst(40, 16, 1);
        tick();
        tick();
        RESET = 1'b1;
        do_write(1, 40, 30'h3FFFFFF);
        RESET = 1'b0;
        check_val("abort_busy", 256'(busy), 256'(0));
        check_val("abort_valid", 256'(rd_valid), 256'(0));
        check_val("abort_done", 256'(burst_done), 256'(0));
        check_val("abort_addr", 256'(rd_address_word), 256'(0));
        check_val("abort_data", 256'(data_words), 256'(0));
        exp_q.delete();
        nv = n_valid;
        nd = n_done;
        repeat (20) tick();
        check_val("abort_no_valid", 256'(n_valid - nv), 256'(0));
        check_val("abort_no_done", 256'(n_done - nd), 256'(0));
        start_burst(40, 16, 1);
        wait_idle(40);

        // zero length and start-while-busy are ignored
        nv = n_valid;
        start_burst(3, 0, 0);
        check_val("len0_busy", 256'(busy), 256'(0));
        repeat (3) tick();
        check_val("len0_nvalid", 256'(n_valid - nv), 256'(0));
        nv = n_valid;
        start_burst(0, 4, 1);
        start_burst(50, 3, 0);
        wait_idle(20);
        repeat (3) tick();
        check_val("busy_start_nvalid", 256'(n_valid - nv), 256'(4));

        // full-depth burst
        nv = n_valid;
        nd = n_done;
        start_burst(77, 128, 1);
        wait_idle(400);
        check_val("full_nvalid", 256'(n_valid - nv), 256'(128));
        check_val("full_ndone", 256'(n_done - nd), 256'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
